// File: rtl/fp_acc_pkg.sv
// Shared saturation helpers for the fixed-point accumulator datapath.
// Values travel through the helpers zero-padded to SAT_W bits; callers truncate back to W.
package fp_acc_pkg;

  localparam int SAT_W = 64;

  typedef logic [SAT_W-1:0] sat_word_t;

  typedef struct packed {
    logic      clamp;
    sat_word_t sum;
  } sat_res_t;

  function automatic sat_word_t smax(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic sat_word_t smin(input int w);
    return ~smax(w);
  endfunction

  function automatic sat_word_t umax(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic sat_word_t extend(input sat_word_t v, input int w, input logic signed_mode);
    sat_word_t m;
    m = umax(w);
    if (signed_mode && (((v >> (w - 1)) & 64'd1) != 64'd0)) begin
      return v | ~m;
    end else begin
      return v & m;
    end
  endfunction

  // Sign/zero-extended add, then clamp to the w-bit range of the selected mode.
  function automatic sat_res_t sat_add(input sat_word_t a, input sat_word_t b, input int w,
                                       input logic signed_mode);
    sat_res_t  r;
    sat_word_t s;
    s       = extend(a, w, signed_mode) + extend(b, w, signed_mode);
    r.clamp = 1'b0;
    r.sum   = s;
    if (signed_mode) begin
      if ($signed(s) > $signed(smax(w))) begin
        r.clamp = 1'b1;
        r.sum   = smax(w);
      end else if ($signed(s) < $signed(smin(w))) begin
        r.clamp = 1'b1;
        r.sum   = smin(w);
      end else begin
        r.sum   = s;
      end
    end else if (s > umax(w)) begin
      r.clamp = 1'b1;
      r.sum   = umax(w);
    end else begin
      r.sum   = s;
    end
    return r;
  endfunction

  function automatic logic sat_clamp(input sat_word_t a, input sat_word_t b, input int w,
                                     input logic signed_mode);
    sat_res_t r;
    r = sat_add(a, b, w, signed_mode);
    return r.clamp;
  endfunction

endpackage

// File: rtl/fp_sat_add_stage.sv
// One registered level of the saturating adder tree: PAIRS adjacent-pair sums per beat.
// Optional sticky saturation bit when FP_ACC_SAT_FLAG_EN is defined.
module fp_sat_add_stage
  import fp_acc_pkg::*;
#(
  parameter int PAIRS  = 1,
  parameter int W      = 16,
  parameter bit SIGNED = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic [2*PAIRS*W-1:0]   in_data,
`ifdef FP_ACC_SAT_FLAG_EN
  input  logic                   in_sat,
  output logic                   out_sat,
`endif
  output logic                   out_valid,
  output logic                   out_last,
  output logic [PAIRS*W-1:0]     out_data
);

  logic [PAIRS*W-1:0] sum_s;
  logic [PAIRS*W-1:0] data_r;
  logic               valid_r;
  logic               last_r;

  // Pairwise saturating sums of adjacent lanes.
  always_comb begin
    sum_s = '0;
    for (int p = 0; p < PAIRS; p++) begin
      sum_s[p*W +: W] = W'(sat_add(SAT_W'(in_data[2*p*W +: W]),
                                   SAT_W'(in_data[(2*p+1)*W +: W]), W, SIGNED));
    end
  end

  // Stage register; holds everything while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      data_r  <= '0;
    end else if (en) begin
      valid_r <= in_valid;
      last_r  <= in_last;
      data_r  <= sum_s;
    end
  end

  assign out_valid = valid_r;
  assign out_last  = last_r;
  assign out_data  = data_r;

`ifdef FP_ACC_SAT_FLAG_EN
  logic clamp_s;
  logic sat_r;

  // Any clamp in this level for this beat.
  always_comb begin
    clamp_s = 1'b0;
    for (int p = 0; p < PAIRS; p++) begin
      clamp_s = clamp_s | sat_clamp(SAT_W'(in_data[2*p*W +: W]),
                                    SAT_W'(in_data[(2*p+1)*W +: W]), W, SIGNED);
    end
  end

  // Sticky flag travels alongside the beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_r <= 1'b0;
    end else if (en) begin
      sat_r <= in_sat | clamp_s;
    end
  end

  assign out_sat = sat_r;
`endif

endmodule

// File: rtl/fp_sat_accumulator.sv
// Streaming saturating accumulator: log2(LANES) registered adder-tree levels, then a packet
// accumulator with a valid/ready result port. Define FP_ACC_SAT_FLAG_EN to add out_sat.
module fp_sat_accumulator
  import fp_acc_pkg::*;
#(
  parameter bit SIGNED   = 1'b1,
  parameter int INTEGER  = 2,
  parameter int FRACTION = 14,
  parameter int LANES    = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [LANES*(INTEGER+FRACTION)-1:0]   in_data,
  input  logic                                  in_last,
  output logic                                  out_valid,
  input  logic                                  out_ready,
`ifdef FP_ACC_SAT_FLAG_EN
  output logic                                  out_sat,
`endif
  output logic [INTEGER+FRACTION-1:0]           out_data
);

  localparam int W     = INTEGER + FRACTION;
  localparam int D     = $clog2(LANES);
  localparam int TOT_W = W * (2 * LANES - 1);
  localparam int T_OFF = W * (2 * LANES - 2);

  // All tree levels packed back to back: level s holds LANES>>s words.
  logic [TOT_W-1:0] lvl_data_s;
  logic [D:0]       lvl_valid_s;
  logic [D:0]       lvl_last_s;
  logic             stall_s;
  logic             en_s;
  logic [W-1:0]     t_s;
  logic [W-1:0]     acc_sum_s;
  logic [W-1:0]     acc_r;
  logic [W-1:0]     out_data_r;
  logic             out_valid_r;

  assign stall_s   = out_valid_r & ~out_ready;
  assign en_s      = ~stall_s;
  assign in_ready  = en_s;

  assign lvl_data_s[0 +: LANES*W] = in_data;
  assign lvl_valid_s[0]           = in_valid;
  assign lvl_last_s[0]            = in_last;

`ifdef FP_ACC_SAT_FLAG_EN
  logic [D:0] lvl_sat_s;
  assign lvl_sat_s[0] = 1'b0;
`endif

  for (genvar s = 0; s < D; s++) begin : g_stage
    localparam int PAIRS   = LANES >> (s + 1);
    localparam int IN_OFF  = W * (2 * LANES - 2 * (LANES >> s));
    localparam int OUT_OFF = W * (2 * LANES - 2 * PAIRS);

    fp_sat_add_stage #(
      .PAIRS  (PAIRS),
      .W      (W),
      .SIGNED (SIGNED)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en_s),
      .in_valid  (lvl_valid_s[s]),
      .in_last   (lvl_last_s[s]),
      .in_data   (lvl_data_s[IN_OFF +: 2*PAIRS*W]),
`ifdef FP_ACC_SAT_FLAG_EN
      .in_sat    (lvl_sat_s[s]),
      .out_sat   (lvl_sat_s[s+1]),
`endif
      .out_valid (lvl_valid_s[s+1]),
      .out_last  (lvl_last_s[s+1]),
      .out_data  (lvl_data_s[OUT_OFF +: PAIRS*W])
    );
  end

  assign t_s       = lvl_data_s[T_OFF +: W];
  assign acc_sum_s = W'(sat_add(SAT_W'(acc_r), SAT_W'(t_s), W, SIGNED));

  // Packet accumulator and result register; a new result may replace one being accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r       <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
    end else if (en_s) begin
      if (lvl_valid_s[D] && lvl_last_s[D]) begin
        out_data_r  <= acc_sum_s;
        out_valid_r <= 1'b1;
        acc_r       <= '0;
      end else if (lvl_valid_s[D]) begin
        acc_r       <= acc_sum_s;
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

`ifdef FP_ACC_SAT_FLAG_EN
  logic acc_sat_r;
  logic out_sat_r;
  logic pkt_sat_s;

  assign pkt_sat_s = acc_sat_r | lvl_sat_s[D] | sat_clamp(SAT_W'(acc_r), SAT_W'(t_s), W, SIGNED);

  // Packet-wide sticky saturation flag, cleared with acc.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_sat_r <= 1'b0;
      out_sat_r <= 1'b0;
    end else if (en_s && lvl_valid_s[D]) begin
      if (lvl_last_s[D]) begin
        out_sat_r <= pkt_sat_s;
        acc_sat_r <= 1'b0;
      end else begin
        acc_sat_r <= pkt_sat_s;
      end
    end
  end

  assign out_sat = out_sat_r;
`endif

endmodule

// File: tb/tb_fp_sat_accumulator.sv
// Bench for fp_sat_accumulator: directed cases plus random packets against an arithmetic model.
module tb_fp_sat_accumulator;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_last, out_ready;
  logic [63:0] in_data;
  logic        in_ready_s4, out_valid_s4, in_ready_u4, out_valid_u4;
  logic [15:0] out_data_s4, out_data_u4;
  logic        in1_valid, in1_last, in1_ready, out1_valid, out1_ready;
  logic [15:0] in1_data, out1_data;
`ifdef FP_ACC_SAT_FLAG_EN
  logic        out_sat_s4, out_sat_u4, out_sat_u1;
`endif

  fp_sat_accumulator #(.SIGNED(1'b1), .INTEGER(2), .FRACTION(14), .LANES(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s4), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_s4), .out_ready(out_ready),
`ifdef FP_ACC_SAT_FLAG_EN
    .out_sat(out_sat_s4),
`endif
    .out_data(out_data_s4));

  fp_sat_accumulator #(.SIGNED(1'b0), .INTEGER(2), .FRACTION(14), .LANES(4)) u_u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u4), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_u4), .out_ready(out_ready),
`ifdef FP_ACC_SAT_FLAG_EN
    .out_sat(out_sat_u4),
`endif
    .out_data(out_data_u4));

  fp_sat_accumulator #(.SIGNED(1'b0), .INTEGER(2), .FRACTION(14), .LANES(1)) u_u1 (
    .clk(clk), .rst(rst), .in_valid(in1_valid), .in_ready(in1_ready), .in_data(in1_data),
    .in_last(in1_last), .out_valid(out1_valid), .out_ready(out1_ready),
`ifdef FP_ACC_SAT_FLAG_EN
    .out_sat(out_sat_u1),
`endif
    .out_data(out1_data));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic: clamp to the 16-bit range of the mode.
  function automatic longint satv(input longint v, input bit sgn, output bit c);
    longint hi, lo;
    hi = sgn ? 64'sd32767 : 64'sd65535;
    lo = sgn ? -64'sd32768 : 64'sd0;
    c  = 1'b0;
    if (v > hi) begin c = 1'b1; return hi; end
    if (v < lo) begin c = 1'b1; return lo; end
    return v;
  endfunction

  function automatic longint tree_model(input logic [63:0] d, input bit sgn, output bit f);
    longint v[4];
    bit     c;
    int     n;
    f = 1'b0;
    for (int k = 0; k < 4; k++)
      v[k] = sgn ? longint'($signed(d[k*16 +: 16])) : longint'(d[k*16 +: 16]);
    n = 4;
    while (n > 1) begin
      for (int i = 0; i < n / 2; i++) begin
        v[i] = satv(v[2*i] + v[2*i+1], sgn, c);
        f = f | c;
      end
      n = n / 2;
    end
    return v[0];
  endfunction

  typedef struct { logic [15:0] ds; bit ss; logic [15:0] du; bit su; } exp_t;
  exp_t   q[$];
  longint m_acc_s, m_acc_u;
  bit     m_sat_s, m_sat_u;
  bit     prev_stall;

  // Scoreboard: model accepted beats, compare every consumed result in order.
  always @(negedge clk) begin : scoreboard
    exp_t   e;
    longint t, s;
    bit     f, c;
    if (rst) begin
      q.delete();
      m_acc_s = 0; m_acc_u = 0; m_sat_s = 1'b0; m_sat_u = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check_val("hold_valid", 32'(out_valid_s4), 32'd1);
      if (out_valid_s4 && !out_ready) begin
        check_val("stall_in_ready_s", 32'(in_ready_s4), 32'd0);
        check_val("stall_in_ready_u", 32'(in_ready_u4), 32'd0);
        if (q.size() == 0) check_val("stall_unexpected", 32'd1, 32'd0);
        else check_val("stall_data", 32'(out_data_s4), 32'(q[0].ds));
      end
      if (out_valid_s4 && out_ready) begin
        if (q.size() == 0) begin
          check_val("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check_val("res_data_s", 32'(out_data_s4), 32'(e.ds));
          check_val("res_valid_u", 32'(out_valid_u4), 32'd1);
          check_val("res_data_u", 32'(out_data_u4), 32'(e.du));
`ifdef FP_ACC_SAT_FLAG_EN
          check_val("res_sat_s", 32'(out_sat_s4), 32'(e.ss));
          check_val("res_sat_u", 32'(out_sat_u4), 32'(e.su));
`endif
        end
      end
      if (in_valid && in_ready_s4) begin
        t = tree_model(in_data, 1'b1, f);
        s = satv(m_acc_s + t, 1'b1, c);
        m_sat_s = m_sat_s | f | c;
        m_acc_s = s;
        e.ds = 16'(s); e.ss = m_sat_s;
        t = tree_model(in_data, 1'b0, f);
        s = satv(m_acc_u + t, 1'b0, c);
        m_sat_u = m_sat_u | f | c;
        m_acc_u = s;
        e.du = 16'(s); e.su = m_sat_u;
        if (in_last) begin
          q.push_back(e);
          m_acc_s = 0; m_acc_u = 0; m_sat_s = 1'b0; m_sat_u = 1'b0;
        end
      end
      prev_stall = out_valid_s4 && !out_ready;
    end
  end

  bit   rand_ready_en = 1'b0;
  logic ready_force   = 1'b1;

  // out_ready is either forced by the directed sequence or randomised.
  always @(posedge clk) begin
    #2;
    out_ready = rand_ready_en ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic last);
    int n;
    in_valid = 1'b1; in_data = d; in_last = last; n = 0;
    @(negedge clk);
    while (!in_ready_s4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_val("beat_accept_timeout", 32'(in_ready_s4), 32'd1);
    sync();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [15:0] ds, input bit ss,
                             input logic [15:0] du, input bit su);
    int n;
    n = 0;
    @(negedge clk);
    while (!(out_valid_s4 && out_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check_val({tag, "_timeout"}, 32'(out_valid_s4), 32'd1);
    end else begin
      check_val({tag, "_s"}, 32'(out_data_s4), 32'(ds));
      check_val({tag, "_u"}, 32'(out_data_u4), 32'(du));
`ifdef FP_ACC_SAT_FLAG_EN
      check_val({tag, "_sat_s"}, 32'(out_sat_s4), 32'(ss));
      check_val({tag, "_sat_u"}, 32'(out_sat_u4), 32'(su));
`endif
    end
    sync();
  endtask

  task automatic beat1(input logic [15:0] d, input logic last, input logic [15:0] exp_d,
                       input bit exp_s);
    check_val("u1_in_ready", 32'(in1_ready), 32'd1);
    in1_valid = 1'b1; in1_data = d; in1_last = last;
    sync();
    in1_valid = 1'b0; in1_last = 1'b0;
    check_val("u1_valid", 32'(out1_valid), 32'(last));
    if (last) begin
      check_val("u1_data", 32'(out1_data), 32'(exp_d));
`ifdef FP_ACC_SAT_FLAG_EN
      check_val("u1_sat", 32'(out_sat_u1), 32'(exp_s));
`endif
    end
  endtask

  function automatic logic [63:0] rand_beat();
    logic [63:0] d;
    for (int k = 0; k < 4; k++)
      d[k*16 +: 16] = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom & 32'h0FFF);
    return d;
  endfunction

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    longint acc1;
    bit     sat1, c;
    logic [15:0] d1;
    logic        l1;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    in1_valid = 1'b0; in1_last = 1'b0; in1_data = '0; out1_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", 32'(in_ready_s4), 32'd1);
    check_val("rst_out_valid", 32'(out_valid_s4), 32'd0);
    check_val("rst_out_data", 32'(out_data_s4), 32'd0);
    check_val("rst_out_valid_u1", 32'(out1_valid), 32'd0);
    check_val("rst_out_data_u1", 32'(out1_data), 32'd0);
`ifdef FP_ACC_SAT_FLAG_EN
    check_val("rst_out_sat", 32'(out_sat_s4), 32'd0);
`endif
    sync();
    rst = 1'b0;
    sync();

    // Single beat with exact latency of three cycles.
    drive_beat(64'h1000_1000_1000_1000, 1'b1);
    @(negedge clk); check_val("lat_cycle1", 32'(out_valid_s4), 32'd0);
    @(negedge clk); check_val("lat_cycle2", 32'(out_valid_s4), 32'd0);
    @(negedge clk); check_val("lat_cycle3", 32'(out_valid_s4), 32'd1);
    check_val("single_beat", 32'(out_data_s4), 32'h4000);
    sync();
    sync();

    drive_beat(64'h0800_0800_0800_0800, 1'b0);
    drive_beat(64'h0800_0800_0800_0800, 1'b1);
    wait_result("two_beat", 16'h4000, 1'b0, 16'h4000, 1'b0);
    drive_beat(64'h1000_1000_1000_1000, 1'b0);
    drive_beat(64'h1000_1000_1000_1000, 1'b1);
    wait_result("two_beat_clamp", 16'h7FFF, 1'b1, 16'h8000, 1'b0);
    drive_beat(64'hC000_C000_C000_C000, 1'b1);
    wait_result("neg_clamp", 16'h8000, 1'b1, 16'hFFFF, 1'b1);
    drive_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    wait_result("all_ones", 16'hFFFC, 1'b0, 16'hFFFF, 1'b1);

    // Backpressure: three results queue up behind a held output.
    ready_force = 1'b0;
    drive_beat(64'h0400_0400_0400_0400, 1'b1);
    drive_beat(64'h0800_0800_0800_0800, 1'b1);
    drive_beat(64'h0C00_0C00_0C00_0C00, 1'b1);
    repeat (6) sync();
    @(negedge clk);
    check_val("bp_in_ready", 32'(in_ready_s4), 32'd0);
    check_val("bp_out_valid", 32'(out_valid_s4), 32'd1);
    check_val("bp_out_data", 32'(out_data_s4), 32'h1000);
    sync();
    ready_force = 1'b1;
    wait_result("bp_first", 16'h1000, 1'b0, 16'h1000, 1'b0);
    wait_result("bp_second", 16'h2000, 1'b0, 16'h2000, 1'b0);
    wait_result("bp_third", 16'h3000, 1'b0, 16'h3000, 1'b0);

    // Reset in the middle of a packet discards the partial sum.
    drive_beat(64'h1000_1000_1000_1000, 1'b0);
    drive_beat(64'h1000_1000_1000_1000, 1'b0);
    sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    check_val("midrst_out_valid", 32'(out_valid_s4), 32'd0);
    drive_beat(64'h0400_0400_0400_0400, 1'b1);
    wait_result("midrst_result", 16'h1000, 1'b0, 16'h1000, 1'b0);

    // Random packets, bubbles and random backpressure.
    rand_ready_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) sync();
      drive_beat(rand_beat(), ($urandom_range(0, 3) == 0) || (i == 299));
    end
    rand_ready_en = 1'b0;
    ready_force   = 1'b1;
    for (int n = 0; n < 200 && q.size() != 0; n++) @(negedge clk);
    check_val("drain_empty", 32'(q.size()), 32'd0);
    sync();

    // Single-lane unsigned instance: latency of one cycle.
    beat1(16'h1234, 1'b1, 16'h1234, 1'b0);
    beat1(16'hF000, 1'b0, 16'h0000, 1'b0);
    beat1(16'h2000, 1'b1, 16'hFFFF, 1'b1);
    acc1 = 0; sat1 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      d1 = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom & 32'h0FFF);
      l1 = ($urandom_range(0, 2) == 0) || (i == 39);
      acc1 = satv(acc1 + longint'(d1), 1'b0, c);
      sat1 = sat1 | c;
      beat1(d1, l1, 16'(acc1), sat1);
      if (l1) begin
        acc1 = 0; sat1 = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
